fabric_del_tag_top: RTL and testbench
=====================================

Name: fabric_del_tag_top

Overview:
- Tag-stripping stage for the dataflow fabric.
- Accepts a tagged token {tag, data} on a valid/ready input and emits only the data field on a valid/ready output; the tag is discarded.
- Sits between a tagged fabric channel and an untagged consumer.
- Registered through a 2-entry skid buffer, giving full throughput and registered outputs.

Parameters:
- DATA_WIDTH, 32: width of the payload field; must be >= 1.
- TAG_WIDTH, 4: width of the tag field in the input MSBs; must be >= 1 (elaboration-time error otherwise).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input token valid.
- in_ready  output  1  block can accept an input token this cycle.
- in_data  input  TAG_WIDTH+DATA_WIDTH (36)  tagged token: tag = in_data[35:32], data = in_data[31:0].
- out_valid  output  1  output token valid.
- out_ready  input  1  downstream accepts the output token.
- out_data  output  DATA_WIDTH (32)  untagged payload.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: both skid entries empty; out_valid=0, in_ready=1 (once rst_n is high), out_data=0.
- Reset asserted mid-operation: buffered tokens are dropped immediately (asynchronously). No token is emitted after reset deassertion until a new input handshake occurs.
- Input handshake: fires when in_valid && in_ready at a rising edge. Only in_data[DATA_WIDTH-1:0] is captured; the tag bits are ignored entirely, with no check or filtering on tag value.
- Output handshake: fires when out_valid && out_ready at a rising edge.
- Latency: an accepted token appears on out_valid/out_data on the cycle after acceptance (1-cycle latency). There is no combinational path from in_* to out_*.
- Throughput: one token per cycle while out_ready=1.
- Skid buffer:
  - Main register plus skid register.
  - in_ready is driven from a register and equals "skid entry empty".
  - When the main register holds a token and out_ready=0, one further token may be accepted into the skid register; in_ready then drops to 0.
  - When out_ready rises, main is consumed and the skid token moves to main on the same edge; in_ready returns to 1 the next cycle.
- Ordering: strict FIFO, no loss, no duplication.
- Simultaneous input and output handshake with main full and skid empty: main is replaced by the new token and out_valid stays 1.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold stable (AXI-style). in_valid may be deasserted at any time without affecting buffered data.
- out_data while out_valid=0: holds the last value; consumers must not rely on it.

Decomposition:
- Shared package fabric_pkg: localparam defaults FABRIC_DATA_WIDTH=32 and FABRIC_TAG_WIDTH=4, plus a parameterised helper for tagged-token width (TAG_WIDTH+DATA_WIDTH).
- Continue including the existing fabric_common.svh.
- One sub-module: fabric_skid_buffer (parameter WIDTH). It implements the 2-entry registered valid/ready buffer.
- Top level: slices off the tag and instantiates fabric_skid_buffer with WIDTH=DATA_WIDTH.

Test Plan:
- Single token: reset 3 cycles, out_ready=1, send in_data={4'hA,32'hDEAD_BEEF} -> accepted immediately, out_valid next cycle, out_data=32'hDEAD_BEEF, one output only.
- Tag ignored: send {4'h0,32'h1234_5678} then {4'hF,32'h1234_5678} -> two outputs, both 32'h1234_5678.
- Backpressure: out_ready=0, send 0x1, 0x2, 0x3 -> first two accepted, in_ready=0 on the third. Raise out_ready -> outputs 0x1, 0x2, 0x3 in order, out_data stable while stalled.
- Streaming: out_ready=1, in_valid held high with data 0..15 on consecutive cycles -> 16 outputs on 16 consecutive cycles, values 0..15, in_ready never deasserts.
- Random stalls: random in_valid/out_ready over 1000 tokens -> scoreboard matches data[31:0] in order, no drops or duplicates.
- Reset mid-stream: two tokens buffered with out_ready=0, assert rst_n=0 asynchronously -> out_valid=0 immediately, in_ready=1 after release, no stale tokens emitted.

Source files
------------

// File: rtl/fabric_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_pkg
//  Description : Shared definitions for the dataflow fabric: default field
//                widths, skid-buffer occupancy encoding and a helper that
//                computes the width of a tagged token.
//  Revision    : 1.0  initial release
// ============================================================================
package fabric_pkg;

    localparam int FABRIC_DATA_WIDTH = 32;
    localparam int FABRIC_TAG_WIDTH  = 4;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,   // nothing buffered
        SKID_MAIN  = 2'd1,   // main register holds a token
        SKID_FULL  = 2'd2    // main and skid registers both hold tokens
    } skid_state_e;

    // Width of a {tag, data} token
    function automatic int tagged_width(input int data_width, input int tag_width);
        return data_width + tag_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fabric_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_skid_buffer
//  Description : Two-entry registered valid/ready buffer (main + skid).
//                Full throughput, registered outputs, no combinational path
//                from the input side to the output side.
//  Revision    : 1.0  initial release
// ============================================================================
module fabric_skid_buffer
    import fabric_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      r_state;
    skid_state_e      w_state_next;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // in_ready comes straight from the state register: high while the skid slot is free
    assign in_ready  = (r_state != SKID_FULL);
    assign out_valid = (r_state != SKID_EMPTY);
    assign out_data  = r_main_data;
    assign w_in_fire = in_valid && in_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy and which data register to load this cycle
    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main  = 1'b1;
                    w_state_next = SKID_MAIN;
                end
            end
            SKID_MAIN: begin
                if (out_ready) begin
                    // Main drains; a simultaneous input simply replaces it
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                    end else begin
                        w_state_next = SKID_EMPTY;
                    end
                end else if (w_in_fire) begin
                    w_load_skid  = 1'b1;
                    w_state_next = SKID_FULL;
                end
            end
            SKID_FULL: begin
                // No input accepted here; skid token moves up when main drains
                if (out_ready) begin
                    w_main_from_skid = 1'b1;
                    w_state_next     = SKID_MAIN;
                end
            end
            default: begin
                w_state_next = SKID_EMPTY;
            end
        endcase
    end

    // Data registers; main keeps its last value when the buffer empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main) begin
                r_main_data <= in_data;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fabric_del_tag_top.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_del_tag_top
//  Description : Tag-stripping stage. Accepts {tag, data} tokens and emits
//                only the data field through a registered skid buffer. Tag
//                values are never inspected.
//  Revision    : 1.0  initial release
// ============================================================================
module fabric_del_tag_top
    import fabric_pkg::*;
#(
    parameter int DATA_WIDTH = FABRIC_DATA_WIDTH,
    parameter int TAG_WIDTH  = FABRIC_TAG_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [tagged_width(DATA_WIDTH, TAG_WIDTH)-1:0] in_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_WIDTH-1:0]                         out_data
);

    localparam int c_IN_WIDTH = tagged_width(DATA_WIDTH, TAG_WIDTH);

    if (TAG_WIDTH < 1) begin : g_bad_tag_width
        $error("fabric_del_tag_top: TAG_WIDTH must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fabric_del_tag_top: DATA_WIDTH must be >= 1");
    end

    logic [DATA_WIDTH-1:0] w_payload;
    logic                  w_unused_tag;

    // Tag bits are dropped; the reduction only marks them as intentionally unused
    assign w_payload    = in_data[DATA_WIDTH-1:0];
    assign w_unused_tag = ^in_data[c_IN_WIDTH-1:DATA_WIDTH];

    fabric_skid_buffer #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fabric_del_tag_top.sv
`timescale 1ns/1ps
module tb_fabric_del_tag_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [35:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    fabric_del_tag_top #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int cyc      = 0;
    bit stream_mode = 1'b0;
    int stream_first = -1;
    int stream_last  = -1;
    bit          stalled = 1'b0;
    logic [31:0] held_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge; handshakes complete on the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (stream_mode) begin
                    if (stream_first < 0) stream_first = cyc;
                    stream_last = cyc;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    chk("scoreboard", out_data, exp_q.pop_front());
                end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    // Drive one token; waits until accepted and records the number of cycles waited
    task automatic send(input logic [3:0] tag, input logic [31:0] data, output int waits);
        bit acc;
        waits = 0;
        in_valid = 1'b1;
        in_data  = {tag, data};
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back(data);
            @(posedge clk); #1;
            waits++;
            if (waits > 200) begin
                $display("FAIL send_timeout: got no accept expected accept");
                n_checks++; n_fail++;
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int w;
    int base;
    int stall_waits;
    bit rand_done;

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_data", out_data, 32'd0);
        @(posedge clk); #1;

        // Single token, 1-cycle latency
        out_ready = 1'b1;
        base = n_out;
        send(4'hA, 32'hDEAD_BEEF, w);
        chk("single_accept_waits", w, 1);
        chk("single_out_valid", {31'd0, out_valid}, 32'd1);
        chk("single_out_data", out_data, 32'hDEAD_BEEF);
        drain();
        chk("single_count", n_out - base, 1);

        // Tag ignored
        base = n_out;
        send(4'h0, 32'h1234_5678, w);
        send(4'hF, 32'h1234_5678, w);
        drain();
        chk("tag_count", n_out - base, 2);

        // Backpressure
        out_ready = 1'b0;
        base = n_out;
        send(4'h1, 32'h1, w);
        send(4'h2, 32'h2, w);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_out_data", out_data, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_still_blocked", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        send(4'h3, 32'h3, w);
        drain();
        chk("bp_count", n_out - base, 3);

        // Streaming 0..15 back to back
        base = n_out;
        stall_waits = 0;
        stream_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(4'(i), 32'(i), w);
            stall_waits += w - 1;
        end
        drain();
        stream_mode = 1'b0;
        chk("stream_count", n_out - base, 16);
        chk("stream_in_ready_stalls", stall_waits, 0);
        chk("stream_span", stream_last - stream_first, 15);

        // Random stalls
        base = n_out;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(4'($urandom), $urandom, w);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("random_count", n_out - base, 1000);

        // Reset mid-stream with two tokens buffered
        out_ready = 1'b0;
        send(4'h5, 32'hAAAA_0001, w);
        send(4'h6, 32'hAAAA_0002, w);
        chk("mid_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        base = n_out;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_stale", n_out - base, 0);
        send(4'h7, 32'hCAFE_F00D, w);
        drain();
        chk("post_rst_count", n_out - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
